// File: rtl/timer_intc.sv
// Interrupt controller behind the timer: edge-captured pending bits, mask, fixed priority, irq/ack/EOI handshake.
// Optional macro TIMER_INTC_PSLVERR_EN enables error responses for unmapped addresses and stray EOI writes.
module timer_intc #(
    parameter int N_SRC  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [N_SRC-1:0]  src,
    output logic              irq,
    output logic [2:0]        irq_id,
    input  logic              irq_ack
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    localparam logic [ADDR_W-1:0] A_IER  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_IPR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ISVR = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_ICR  = ADDR_W'(3);

    state_t             state;
    logic [N_SRC-1:0]   ier;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   src_q;
    logic               gie;
    logic               isvr_valid;
    logic [2:0]         isvr_id;

    logic               access;
    logic               wr;
    logic               sel_ier, sel_ipr, sel_isvr, sel_icr, mapped;
    logic               eoi;
    logic               err;
    logic [7:0]         rdata;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   candidate;
    logic [N_SRC-1:0]   id_mask;
    logic [N_SRC-1:0]   ack_mask;
    logic [N_SRC-1:0]   pending_nxt;
    logic [2:0]         winner;
    logic               unused_wdata;

    // A transfer commits on the second access cycle, the one where pready is already high.
    assign access   = psel & penable;
    assign wr       = access & pready & pwrite;
    assign sel_ier  = (paddr == A_IER);
    assign sel_ipr  = (paddr == A_IPR);
    assign sel_isvr = (paddr == A_ISVR);
    assign sel_icr  = (paddr == A_ICR);
    assign mapped   = sel_ier | sel_ipr | sel_isvr | sel_icr;
    assign eoi      = wr & sel_isvr & (state == SVC);

`ifdef TIMER_INTC_PSLVERR_EN
    assign err = ~mapped | (pwrite & sel_isvr & (state != SVC));
`else
    assign err = 1'b0;
`endif

    assign unused_wdata = ^pwdata;

    assign rise        = src & ~src_q;
    assign w1c         = (wr & sel_ipr) ? pwdata[N_SRC-1:0] : '0;
    assign candidate   = gie ? (pending & ier) : '0;
    assign id_mask     = N_SRC'(1) << irq_id;
    assign ack_mask    = (state == REQ && irq_ack) ? id_mask : '0;
    // A fresh edge beats a same-cycle clear, so no event is lost.
    assign pending_nxt = (pending & ~w1c & ~ack_mask) | rise;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rdata = '0;
        if (sel_ier)       rdata = 8'(ier);
        else if (sel_ipr)  rdata = 8'(pending);
        else if (sel_isvr) rdata = {isvr_valid, 4'b0, isvr_id};
        else if (sel_icr)  rdata = {7'b0, gie};
    end

    // Scan downward so the lowest-numbered candidate is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (candidate[i]) winner = 3'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= IDLE;
            ier        <= '0;
            pending    <= '0;
            src_q      <= '0;
            gie        <= 1'b0;
            isvr_valid <= 1'b0;
            isvr_id    <= '0;
            irq        <= 1'b0;
            irq_id     <= '0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
        end else begin
            src_q   <= src;
            pending <= pending_nxt;
            if (wr & sel_ier) ier <= pwdata[N_SRC-1:0];
            if (wr & sel_icr) gie <= pwdata[0];

            if (access && !pready) begin
                pready  <= 1'b1;
                prdata  <= rdata;
                pslverr <= err;
            end else begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|candidate) begin
                        state  <= REQ;
                        irq    <= 1'b1;
                        irq_id <= winner;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state      <= SVC;
                        irq        <= 1'b0;
                        isvr_valid <= 1'b1;
                        isvr_id    <= irq_id;
                    end else if (!(|(candidate & id_mask))) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                SVC: begin
                    if (eoi) begin
                        state      <= IDLE;
                        isvr_valid <= 1'b0;
                        isvr_id    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/timer_intc.md
Name: timer_intc

Overview:
- Interrupt controller directly downstream of the timer block.
- Latches the timer's overflow/underflow status plus external sources as pending bits, then masks and prioritises them.
- Drives a single irq line with an ack/EOI handshake toward the CPU.
- Programmed over the same 8-bit APB-style bus, clocked by pclk.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); src[0] = timer overflow, src[1] = timer underflow, the rest external.
- ADDR_W, 8, paddr width.

Ports:
- pclk  input  1  system/bus clock.
- preset  input  1  asynchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  register address.
- pwdata  input  8  write data.
- prdata  output  8  read data, valid when pready=1.
- pready  output  1  transfer complete.
- pslverr  output  1  error response (see Optional Feature).
- src  input  N_SRC  source levels, synchronous to pclk.
- irq  output  1  interrupt request to CPU, level.
- irq_id  output  3  index of the source being requested or serviced.
- irq_ack  input  1  one-cycle CPU acknowledge.

Behaviour:
- Reset: async on preset=1. All registers 0; irq=0, irq_id=0, prdata=0, pready=0, pslverr=0; FSM=IDLE.
- Register map (8-bit; bits >= N_SRC read 0, writes ignored):
  - 0x00 IER: per-source enable, R/W.
  - 0x01 IPR: pending. Read returns pending; write-1-to-clear.
  - 0x02 ISVR: bit7 = in-service valid, [2:0] = in-service id. Read-only; any write = EOI.
  - 0x03 ICR: bit0 = global enable (GIE), R/W.
- APB timing:
  - Setup: psel=1, penable=0.
  - Access: first cycle pready=0 (one wait state); second cycle pready=1, prdata valid, write committed.
  - pready is a one-cycle pulse. Back-to-back transfers are allowed.
  - Unmapped address: read returns 0, write has no effect.
- Source capture:
  - src sampled every cycle; rising edge (src & ~src_q) sets the pending bit, independent of IER.
  - Same-cycle set and W1C of the same bit: set wins.
- Arbitration: candidate = pending & IER when GIE=1; lowest set index wins.
- FSM:
  - IDLE: candidate != 0 -> REQ. On entry irq=1, irq_id=winner; irq_id is frozen while in REQ.
  - REQ: irq_ack=1 -> SVC. That pending bit clears, ISVR={1,id}, irq=0.
  - REQ: winner disabled (IER bit or GIE cleared) before ack -> IDLE, irq=0 next cycle, pending kept.
  - SVC: no nesting; new pendings accumulate. EOI write -> IDLE, ISVR bit7=0.
  - IDLE after EOI: candidate still nonzero -> REQ on the next cycle (irq re-asserts 2 cycles after EOI commit).
- Latency: src edge at cycle N -> pending set at N+1 -> irq=1 at N+2.
- Edge cases:
  - irq_ack outside REQ is ignored.
  - EOI outside SVC is ignored.
  - A src edge on the in-service source during SVC sets pending again.
  - Reset mid-transfer aborts it; pready=0.

Optional Feature:
- Macro TIMER_INTC_PSLVERR_EN.
- Defined:
  - pslverr=1 together with pready for an unmapped address.
  - pslverr=1 together with pready for a write to ISVR while not in SVC.
  - Register state is unchanged in both error cases.
- Undefined: pslverr tied to 0; same cases complete silently.

Test Plan:
- Reset, then read 0x00-0x03 -> all 8'h00; irq=0.
- IER=8'h03, ICR=8'h01; pulse src[1] (timer underflow) -> IPR=8'h02; irq=1, irq_id=1 two cycles after the edge. Pulse irq_ack -> irq=0, ISVR=8'h81, IPR=8'h00. Write ISVR -> ISVR=8'h00.
- Pulse src[0] and src[1] in the same cycle -> irq_id=0 first. After ack + EOI -> irq re-asserts with irq_id=1 two cycles after EOI.
- IER=8'h00; pulse src[1] -> IPR=8'h02, irq stays 0. Write IER=8'h02 -> irq=1, irq_id=1. Write IPR=8'h02 before ack -> IPR=8'h00, FSM returns to IDLE, irq=0.
- During SVC of id 0, pulse src[0] -> IPR=8'h01, irq=0 until EOI, then irq=1, irq_id=0.
- With TIMER_INTC_PSLVERR_EN: read 0x05 -> pslverr=1, prdata=8'h00. Write ISVR in IDLE -> pslverr=1. Without the macro, both transfers give pslverr=0.
